// File: rtl/mem_burst_ctrl.sv
// Line-burst engine: moves one whole cache line per request over a narrow memory bus,
// with a response timeout and a one-cycle completion pulse back to the cache.
module mem_burst_ctrl #(
   parameter int unsigned BUS_SIZE          = 16,
   parameter int unsigned MEM_ADDR_SIZE     = 19,
   parameter int unsigned CACHE_OFFSET_SIZE = 4,
   parameter int unsigned CACHE_LINE_SIZE   = 16,
   parameter int unsigned TIMEOUT           = 255
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       req_valid,
   output logic                                       req_ready,
   input  logic                                       req_write,
   input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] req_addr,
   input  logic [CACHE_LINE_SIZE*8-1:0]               req_wdata,
   output logic                                       resp_valid,
   output logic                                       resp_err,
   output logic [CACHE_LINE_SIZE*8-1:0]               resp_rdata,
   output logic [1:0]                                 mem_cmd,
   output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] mem_addr,
   output logic [BUS_SIZE-1:0]                        mem_wdata,
   input  logic                                       mem_resp,
   input  logic [BUS_SIZE-1:0]                        mem_rdata
);

   localparam int unsigned LA    = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
   localparam int unsigned LB    = CACHE_LINE_SIZE * 8;
   localparam int unsigned BEATS = LB / BUS_SIZE;
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned TW    = $clog2(TIMEOUT + 1);

   localparam logic [1:0] CMD_NOP   = 2'd0;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_WRITE = 2'd3;

   typedef enum logic [2:0] {
      IDLE, RD_CMD, RD_WAIT, RD_DATA, WR_DATA, WR_WAIT, RESP
   } state_e;

   state_e            state_q, state_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [LA-1:0]     addr_q, addr_d;
   logic [LB-1:0]     wbuf_q, wbuf_d;
   logic [LB-1:0]     rdata_q, rdata_d;
   logic [1:0]        mem_cmd_q, mem_cmd_d;
   logic [BUS_SIZE-1:0] mem_wdata_q, mem_wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic              req_ready_q, req_ready_d;

   // Next-state and next-output logic; outputs are registered from the state being entered.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      timer_d     = timer_q;
      addr_d      = addr_q;
      wbuf_d      = wbuf_q;
      rdata_d     = rdata_q;
      mem_cmd_d   = CMD_NOP;
      mem_wdata_d = mem_wdata_q;
      resp_err_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               addr_d = req_addr;
               beat_d = '0;
               if (req_write) begin
                  state_d     = WR_DATA;
                  mem_cmd_d   = CMD_WRITE;
                  mem_wdata_d = req_wdata[BUS_SIZE-1:0];
                  wbuf_d      = req_wdata >> BUS_SIZE;
               end else begin
                  state_d   = RD_CMD;
                  mem_cmd_d = CMD_READ;
               end
            end
         end
         RD_CMD: begin
            state_d = RD_WAIT;
            timer_d = TW'(TIMEOUT);
         end
         RD_WAIT: begin
            if (mem_resp) begin
               rdata_d = LB'({mem_rdata, rdata_q} >> BUS_SIZE);
               beat_d  = BW'(1);
               state_d = (BEATS == 1) ? RESP : RD_DATA;
            end else if (timer_q <= TW'(1)) begin
               state_d    = RESP;
               resp_err_d = 1'b1;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         RD_DATA: begin
            if (mem_resp) begin
               rdata_d = LB'({mem_rdata, rdata_q} >> BUS_SIZE);
               if (beat_q == BW'(BEATS - 1)) begin
                  state_d = RESP;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end else begin
               // Beats must be back to back; a gap aborts the burst.
               state_d    = RESP;
               resp_err_d = 1'b1;
            end
         end
         WR_DATA: begin
            if (beat_q == BW'(BEATS - 1)) begin
               state_d = WR_WAIT;
               timer_d = TW'(TIMEOUT);
            end else begin
               beat_d      = beat_q + BW'(1);
               mem_cmd_d   = CMD_WRITE;
               mem_wdata_d = wbuf_q[BUS_SIZE-1:0];
               wbuf_d      = wbuf_q >> BUS_SIZE;
            end
         end
         WR_WAIT: begin
            if (mem_resp) begin
               state_d = RESP;
            end else if (timer_q <= TW'(1)) begin
               state_d    = RESP;
               resp_err_d = 1'b1;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      resp_valid_d = (state_d == RESP);
      req_ready_d  = (state_d == IDLE);
   end

   // State and output registers; reset drops any burst in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         timer_q      <= '0;
         addr_q       <= '0;
         wbuf_q       <= '0;
         rdata_q      <= '0;
         mem_cmd_q    <= CMD_NOP;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         req_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         timer_q      <= timer_d;
         addr_q       <= addr_d;
         wbuf_q       <= wbuf_d;
         rdata_q      <= rdata_d;
         mem_cmd_q    <= mem_cmd_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         req_ready_q  <= req_ready_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = rdata_q;
   assign mem_cmd    = mem_cmd_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: a table of line transactions plus hand sequences
// for back-to-back requests and reset in the middle of a write burst.
module tb_mem_burst_ctrl;

   localparam int BEATS   = 8;
   localparam int TMO     = 10;

   logic           clk = 1'b0;
   logic           reset;
   logic           req_valid;
   logic           req_ready;
   logic           req_write;
   logic [14:0]    req_addr;
   logic [127:0]   req_wdata;
   logic           resp_valid;
   logic           resp_err;
   logic [127:0]   resp_rdata;
   logic [1:0]     mem_cmd;
   logic [14:0]    mem_addr;
   logic [15:0]    mem_wdata;
   logic           mem_resp;
   logic [15:0]    mem_rdata;

   int passed = 0;
   int total  = 0;

   mem_burst_ctrl #(
      .BUS_SIZE(16), .MEM_ADDR_SIZE(19), .CACHE_OFFSET_SIZE(4),
      .CACHE_LINE_SIZE(16), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic         wr;
      logic [14:0]  addr;
      logic [127:0] wdata;
      int           lat;     // read: first beat in cycle 1+lat; write: ack in cycle BEATS+lat; <0 = never
      int           drop;    // read beat index replaced by a gap, -1 = none
      bit           noise;   // write: stray mem_resp in cycle 3
      logic [15:0]  base;    // read beat k value = base+k
      logic         exp_err;
      logic [127:0] exp_rdata;
      int           exp_cyc;
   } vec_t;

   function automatic vec_t mk(input string n, input logic wr, input logic [14:0] a,
                               input logic [127:0] wd, input int lat, input int drop,
                               input bit noise, input logic [15:0] base, input logic err,
                               input logic [127:0] rd, input int cyc);
      vec_t v;
      v.name = n; v.wr = wr; v.addr = a; v.wdata = wd; v.lat = lat; v.drop = drop;
      v.noise = noise; v.base = base; v.exp_err = err; v.exp_rdata = rd; v.exp_cyc = cyc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         passed++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory model: drives mem_resp/mem_rdata for the given cycle of a transaction.
   task automatic drive_mem(input vec_t v, input int cyc);
      int k;
      mem_resp  = 1'b0;
      mem_rdata = 16'hDEAD;
      if (v.lat >= 0) begin
         if (!v.wr) begin
            k = cyc - (1 + v.lat);
            if (k >= 0 && k != v.drop && (k < BEATS || (v.drop >= 0 && k < BEATS + 3))) begin
               mem_resp  = 1'b1;
               mem_rdata = 16'(v.base + 16'(k));
            end
         end else if (cyc == BEATS + v.lat) begin
            mem_resp = 1'b1;
         end
      end
      if (v.wr && v.noise && cyc == 3) mem_resp = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 60 && !req_ready; i++) step();
      chk({name, " ready_before"}, 128'(req_ready), 128'(1));
   endtask

   task automatic run_txn(input vec_t v);
      int cyc, resp_cyc, n_rd, n_wr, rd_cyc, wr_first, busy_ready, extra;
      logic got_err;
      logic [127:0] got_rdata, wd_seen;
      logic addr_ok;
      wait_idle(v.name);
      req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
      step();
      req_valid = 1'b0; req_wdata = '0; req_addr = '0;
      cyc = 1; resp_cyc = -1; n_rd = 0; n_wr = 0; rd_cyc = -1; wr_first = -1;
      busy_ready = 0; extra = 0; got_err = 1'bx; got_rdata = '0; wd_seen = '0; addr_ok = 1'b1;
      while (cyc <= 60 && resp_cyc < 0) begin
         if (mem_cmd == 2'd2) begin n_rd++; rd_cyc = cyc; end
         if (mem_cmd == 2'd3) begin
            n_wr++;
            if (wr_first < 0) wr_first = cyc;
            if (cyc <= BEATS) wd_seen[(cyc-1)*16 +: 16] = mem_wdata;
         end
         if (mem_cmd != 2'd0 && mem_addr !== v.addr) addr_ok = 1'b0;
         if (resp_valid) begin
            resp_cyc = cyc; got_err = resp_err; got_rdata = resp_rdata;
         end else if (req_ready) begin
            busy_ready++;
         end
         drive_mem(v, cyc);
         step();
         cyc++;
      end
      chk({v.name, " resp_cycle"}, 128'(resp_cyc), 128'(v.exp_cyc));
      chk({v.name, " resp_err"}, 128'(got_err), 128'(v.exp_err));
      chk({v.name, " ready_low_busy"}, 128'(busy_ready), 128'(0));
      chk({v.name, " mem_addr"}, 128'(addr_ok), 128'(1));
      if (v.wr) begin
         chk({v.name, " wr_cmd_count"}, 128'(n_wr), 128'(BEATS));
         chk({v.name, " wr_cmd_first"}, 128'(wr_first), 128'(1));
         chk({v.name, " rd_cmd_count"}, 128'(n_rd), 128'(0));
         chk({v.name, " wdata_beats"}, wd_seen, v.wdata);
      end else begin
         chk({v.name, " rd_cmd_count"}, 128'(n_rd), 128'(1));
         chk({v.name, " rd_cmd_cycle"}, 128'(rd_cyc), 128'(1));
         chk({v.name, " wr_cmd_count"}, 128'(n_wr), 128'(0));
         if (!v.exp_err) chk({v.name, " rdata"}, got_rdata, v.exp_rdata);
      end
      // Cycle after RESP: idle again; stray beats must not produce another response.
      chk({v.name, " ready_after"}, 128'(req_ready), 128'(1));
      for (int i = 0; i < 3; i++) begin
         if (resp_valid || mem_cmd != 2'd0) extra++;
         drive_mem(v, cyc);
         step();
         cyc++;
      end
      chk({v.name, " quiet_after"}, 128'(extra), 128'(0));
      mem_resp = 1'b0;
   endtask

   vec_t vecs[7];

   initial begin
      int cyc, first_resp, acc, first_wr, second_resp, n_rd;
      logic err2, wr_addr_ok;
      logic [127:0] rd1;
      logic [127:0] w2, w3;

      vecs[0] = mk("t1_read", 1'b0, 15'h1234, '0, 5, -1, 1'b0, 16'h0001, 1'b0,
                   128'h0008_0007_0006_0005_0004_0003_0002_0001, 14);
      vecs[1] = mk("t2_write", 1'b1, 15'h0ABC,
                   128'hBEEF_BEEF_BEEF_BEEF_BEEF_BEEF_BEEF_1111, 3, -1, 1'b0, 16'h0, 1'b0, '0, 12);
      vecs[2] = mk("t3_rd_timeout", 1'b0, 15'h0777, '0, -1, -1, 1'b0, 16'h0, 1'b1, '0, 12);
      vecs[3] = mk("t4_rd_gap", 1'b0, 15'h0010, '0, 2, 4, 1'b0, 16'h00A0, 1'b1, '0, 8);
      vecs[4] = mk("rd_min_lat", 1'b0, 15'h0000, '0, 1, -1, 1'b0, 16'h0100, 1'b0,
                   128'h0107_0106_0105_0104_0103_0102_0101_0100, 10);
      vecs[5] = mk("wr_min_ack", 1'b1, 15'h7FFF,
                   128'h8888_7777_6666_5555_4444_3333_2222_1111, 1, -1, 1'b1, 16'h0, 1'b0, '0, 10);
      vecs[6] = mk("wr_timeout", 1'b1, 15'h4321,
                   128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878, -1, -1, 1'b0, 16'h0, 1'b1, '0, 19);

      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      mem_resp = 1'b0; mem_rdata = '0;
      #12;
      chk("reset mem_cmd", 128'(mem_cmd), 128'(0));
      chk("reset resp_valid", 128'(resp_valid), 128'(0));
      chk("reset resp_err", 128'(resp_err), 128'(0));
      chk("reset mem_addr", 128'(mem_addr), 128'(0));
      chk("reset mem_wdata", 128'(mem_wdata), 128'(0));
      chk("reset resp_rdata", resp_rdata, 128'(0));
      @(posedge clk); #1;
      reset = 1'b1;
      step();
      chk("release req_ready", 128'(req_ready), 128'(1));

      foreach (vecs[i]) run_txn(vecs[i]);

      // Back-to-back: read then write held on req_valid; write accepted right after RESP.
      w2 = 128'hA7A6_A5A4_A3A2_A1A0_9F9E_9D9C_9B9A_9998;
      wait_idle("t5");
      req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0055; req_wdata = '0;
      step();
      req_write = 1'b1; req_addr = 15'h0066; req_wdata = w2;
      first_resp = -1; acc = -1; first_wr = -1; second_resp = -1; n_rd = 0;
      err2 = 1'bx; rd1 = '0; wr_addr_ok = 1'b0;
      for (cyc = 1; cyc <= 50 && second_resp < 0; cyc++) begin
         if (mem_cmd == 2'd2) n_rd++;
         if (mem_cmd == 2'd3 && first_wr < 0) begin
            first_wr = cyc;
            wr_addr_ok = (mem_addr == 15'h0066);
         end
         if (resp_valid) begin
            if (first_resp < 0) begin first_resp = cyc; rd1 = resp_rdata; end
            else begin second_resp = cyc; err2 = resp_err; end
         end
         if (req_ready && req_valid && acc < 0) acc = cyc;
         if (acc >= 0 && cyc > acc) req_valid = 1'b0;
         mem_resp = 1'b0; mem_rdata = 16'hDEAD;
         if (cyc >= 2 && cyc <= 9) begin mem_resp = 1'b1; mem_rdata = 16'(16'h0200 + 16'(cyc - 2)); end
         if (first_wr >= 0 && cyc == first_wr + BEATS) mem_resp = 1'b1;
         step();
      end
      req_valid = 1'b0; mem_resp = 1'b0;
      chk("t5 read resp_cycle", 128'(first_resp), 128'(10));
      chk("t5 read rdata", rd1, 128'h0207_0206_0205_0204_0203_0202_0201_0200);
      chk("t5 write accept_cycle", 128'(acc), 128'(11));
      chk("t5 write first_cmd", 128'(first_wr), 128'(12));
      chk("t5 write addr", 128'(wr_addr_ok), 128'(1));
      chk("t5 rd_cmd_count", 128'(n_rd), 128'(1));
      chk("t5 write resp_cycle", 128'(second_resp), 128'(21));
      chk("t5 write resp_err", 128'(err2), 128'(0));

      // Reset in the middle of a write burst, then a normal read.
      w3 = 128'h7007_6006_5005_4004_3003_2002_1001_0000;
      wait_idle("t6");
      req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0123; req_wdata = w3;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("t6 beat4 mem_cmd", 128'(mem_cmd), 128'(3));
      chk("t6 beat4 mem_wdata", 128'(mem_wdata), 128'(16'h4004));
      #2 reset = 1'b0;
      #1;
      chk("t6 reset mem_cmd", 128'(mem_cmd), 128'(0));
      chk("t6 reset resp_valid", 128'(resp_valid), 128'(0));
      chk("t6 reset mem_wdata", 128'(mem_wdata), 128'(0));
      @(posedge clk); #1;
      reset = 1'b1;
      step(); step(); step();
      chk("t6 post mem_cmd", 128'(mem_cmd), 128'(0));
      chk("t6 post resp_valid", 128'(resp_valid), 128'(0));
      run_txn(mk("t6_read", 1'b0, 15'h0042, '0, 3, -1, 1'b0, 16'h0040, 1'b0,
                 128'h0047_0046_0045_0044_0043_0042_0041_0040, 12));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
